// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES round sequencer.
// - state_t : sequencer FSM states
// - RC_W    : width of the round counter
// - nr_of() : number of AES rounds for a given key length in 32-bit words
package aes_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    KEY,
    INIT_ARK,
    SUB,
    SHIFT,
    MIX,
    ARK,
    OUT,
    HOLD
  } state_t;

  localparam int unsigned RC_W = 4;

  function automatic int unsigned nr_of(input int unsigned key_words);
    return key_words + 6;
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Host-side handshake bundle of the AES round sequencer.
// master: upstream/downstream controller (drives in_valid, key_load, abort, out_ready)
// slave : sequencer (drives in_ready, out_valid, busy, timeout_err, round_count)
interface aes_round_sequencer_if;
  import aes_ctrl_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic            key_load;
  logic            abort;
  logic            out_valid;
  logic            out_ready;
  logic            busy;
  logic            timeout_err;
  logic [RC_W-1:0] round_count;

  modport master (
    output in_valid, key_load, abort, out_ready,
    input  in_ready, out_valid, busy, timeout_err, round_count
  );

  modport slave (
    input  in_valid, key_load, abort, out_ready,
    output in_ready, out_valid, busy, timeout_err, round_count
  );

endinterface

// File: rtl/aes_step_watchdog.sv
// Per-step watchdog for the AES round sequencer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   restart  : high in the first cycle of a step state (counter restarts)
//   done     : qualified step completion (already masked in the first cycle)
//   enable   : high while the sequencer is in any step state
//   expire   : high in the cycle where the step has been pending TIMEOUT_CYC
//              cycles (counting the first cycle as 1) with done still low
module aes_step_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic done,
  input  logic enable,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  // cnt holds the number of cycles already spent in the step before the
  // current one; it is stale during the restart cycle, hence the split below.
  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= TO_W'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = enable && !done &&
                  (restart ? (TIMEOUT_CYC == 1) : (cnt == LAST));

endmodule

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES datapath (AES-128/192/256 via KEY_WORDS).
// Ports:
//   CLK, RST      : clock, asynchronous active-high reset
//   hs            : host handshake (in_valid/in_ready/key_load/abort,
//                   out_valid/out_ready, busy, timeout_err, round_count)
//   *_done        : datapath step completion levels
//   *_en          : one-cycle step start pulses to the datapath
//   data_sel_init : state source = Data_In (round-0 AddRoundKey)
//   data_sel_final: final-round AddRoundKey select
//   data_out_en   : one-cycle capture pulse for the output register
module aes_round_sequencer
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned KEY_WORDS   = 4,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  aes_round_sequencer_if.slave  hs,
  input  logic                  key_expan_done,
  input  logic                  add_key_done,
  input  logic                  sub_bytes_done,
  input  logic                  shift_rows_done,
  input  logic                  mix_columns_done,
  output logic                  key_expan_en,
  output logic                  add_roundkey_en,
  output logic                  sub_bytes_en,
  output logic                  shift_rows_en,
  output logic                  mix_columns_en,
  output logic                  data_sel_init,
  output logic                  data_sel_final,
  output logic                  data_out_en
);

  localparam int unsigned     NR    = nr_of(KEY_WORDS);
  localparam logic [RC_W-1:0] NR_RC = RC_W'(NR);

  state_t          state;
  logic            key_valid;
  logic            first;       // first cycle of a step state (pulse cycle)
  logic            out_valid;
  logic            timeout_err;
  logic [RC_W-1:0] round_count;
  logic            done_raw;
  logic            step_done;
  logic            in_step;
  logic            expire;

  always_comb begin
    done_raw = 1'b0;
    case (state)
      KEY:           done_raw = key_expan_done;
      INIT_ARK, ARK: done_raw = add_key_done;
      SUB:           done_raw = sub_bytes_done;
      SHIFT:         done_raw = shift_rows_done;
      MIX:           done_raw = mix_columns_done;
      default:       done_raw = 1'b0;
    endcase
  end

  // A done seen during the enable pulse belongs to nothing we started yet.
  assign step_done = done_raw && !first;
  assign in_step   = (state inside {KEY, INIT_ARK, SUB, SHIFT, MIX, ARK});

  aes_step_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_watchdog (
    .clk     (CLK),
    .rst     (RST),
    .restart (first),
    .done    (step_done),
    .enable  (in_step),
    .expire  (expire)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      key_valid       <= 1'b0;
      first           <= 1'b0;
      out_valid       <= 1'b0;
      timeout_err     <= 1'b0;
      round_count     <= '0;
      key_expan_en    <= 1'b0;
      add_roundkey_en <= 1'b0;
      sub_bytes_en    <= 1'b0;
      shift_rows_en   <= 1'b0;
      mix_columns_en  <= 1'b0;
      data_sel_init   <= 1'b0;
      data_sel_final  <= 1'b0;
      data_out_en     <= 1'b0;
    end else begin
      key_expan_en    <= 1'b0;
      add_roundkey_en <= 1'b0;
      sub_bytes_en    <= 1'b0;
      shift_rows_en   <= 1'b0;
      mix_columns_en  <= 1'b0;
      data_out_en     <= 1'b0;
      first           <= 1'b0;

      // abort outranks the watchdog, which outranks normal sequencing
      if (hs.abort) begin
        if (state != IDLE) begin
          state          <= IDLE;
          out_valid      <= 1'b0;
          round_count    <= '0;
          data_sel_init  <= 1'b0;
          data_sel_final <= 1'b0;
          if (state == KEY) key_valid <= 1'b0;
        end
      end else if (expire) begin
        state          <= IDLE;
        timeout_err    <= 1'b1;
        key_valid      <= 1'b0;
        out_valid      <= 1'b0;
        round_count    <= '0;
        data_sel_init  <= 1'b0;
        data_sel_final <= 1'b0;
      end else begin
        case (state)
          IDLE: if (hs.in_valid) begin
            timeout_err <= 1'b0;
            first       <= 1'b1;
            if (hs.key_load || !key_valid) begin
              state        <= KEY;
              key_expan_en <= 1'b1;
            end else begin
              state           <= INIT_ARK;
              add_roundkey_en <= 1'b1;
              data_sel_init   <= 1'b1;
            end
          end
          KEY: if (step_done) begin
            key_valid       <= 1'b1;
            state           <= INIT_ARK;
            add_roundkey_en <= 1'b1;
            data_sel_init   <= 1'b1;
            first           <= 1'b1;
          end
          INIT_ARK: if (step_done) begin
            round_count   <= RC_W'(1);
            data_sel_init <= 1'b0;
            state         <= SUB;
            sub_bytes_en  <= 1'b1;
            first         <= 1'b1;
          end
          SUB: if (step_done) begin
            state         <= SHIFT;
            shift_rows_en <= 1'b1;
            first         <= 1'b1;
          end
          SHIFT: if (step_done) begin
            first <= 1'b1;
            if (round_count < NR_RC) begin
              state          <= MIX;
              mix_columns_en <= 1'b1;
            end else begin
              state           <= ARK;
              add_roundkey_en <= 1'b1;
              data_sel_final  <= 1'b1;
            end
          end
          MIX: if (step_done) begin
            state           <= ARK;
            add_roundkey_en <= 1'b1;
            first           <= 1'b1;
          end
          ARK: if (step_done) begin
            if (round_count < NR_RC) begin
              round_count  <= round_count + 1'b1;
              state        <= SUB;
              sub_bytes_en <= 1'b1;
              first        <= 1'b1;
            end else begin
              data_sel_final <= 1'b0;
              state          <= OUT;
              data_out_en    <= 1'b1;
            end
          end
          OUT: begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
          HOLD: if (hs.out_ready) begin
            out_valid   <= 1'b0;
            round_count <= '0;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign hs.in_ready    = (state == IDLE);
  assign hs.busy        = (state != IDLE);
  assign hs.out_valid   = out_valid;
  assign hs.timeout_err = timeout_err;
  assign hs.round_count = round_count;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: DUT 0 is AES-128 with a short
// watchdog (TIMEOUT_CYC=4), DUT 1 is AES-256 with default watchdog.
module tb_aes_round_sequencer;

  typedef struct {
    int lat; int key; int ark; int sub; int shf; int mix;
    int fin; int ini; int dout; int maxrc; int bad;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  aes_round_sequencer_if ia();
  aes_round_sequencer_if ib();

  logic       kx[2], ae[2], se[2], re[2], me[2], dsi[2], dsf[2], doe[2];
  logic       kd[2], ad[2], sd[2], rd[2], md[2];
  logic       ov[2], rdy[2], bsy[2], ivl[2], abt[2], terr[2];
  logic [3:0] rc[2];
  int         drop_rc = 99;

  aes_round_sequencer #(.KEY_WORDS(4), .TIMEOUT_CYC(4), .TO_W(8)) dut_a (
    .CLK(CLK), .RST(RST), .hs(ia),
    .key_expan_done(kd[0]), .add_key_done(ad[0]), .sub_bytes_done(sd[0]),
    .shift_rows_done(rd[0]), .mix_columns_done(md[0]),
    .key_expan_en(kx[0]), .add_roundkey_en(ae[0]), .sub_bytes_en(se[0]),
    .shift_rows_en(re[0]), .mix_columns_en(me[0]),
    .data_sel_init(dsi[0]), .data_sel_final(dsf[0]), .data_out_en(doe[0])
  );

  aes_round_sequencer #(.KEY_WORDS(8), .TIMEOUT_CYC(255), .TO_W(8)) dut_b (
    .CLK(CLK), .RST(RST), .hs(ib),
    .key_expan_done(kd[1]), .add_key_done(ad[1]), .sub_bytes_done(sd[1]),
    .shift_rows_done(rd[1]), .mix_columns_done(md[1]),
    .key_expan_en(kx[1]), .add_roundkey_en(ae[1]), .sub_bytes_en(se[1]),
    .shift_rows_en(re[1]), .mix_columns_en(me[1]),
    .data_sel_init(dsi[1]), .data_sel_final(dsf[1]), .data_out_en(doe[1])
  );

  assign ov[0]   = ia.out_valid;   assign ov[1]   = ib.out_valid;
  assign rdy[0]  = ia.in_ready;    assign rdy[1]  = ib.in_ready;
  assign bsy[0]  = ia.busy;        assign bsy[1]  = ib.busy;
  assign ivl[0]  = ia.in_valid;    assign ivl[1]  = ib.in_valid;
  assign abt[0]  = ia.abort;       assign abt[1]  = ib.abort;
  assign terr[0] = ia.timeout_err; assign terr[1] = ib.timeout_err;
  assign rc[0]   = ia.round_count; assign rc[1]   = ib.round_count;

  // Datapath model: each step reports done one cycle after its start pulse.
  always @(posedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      kd[d] <= kx[d];
      ad[d] <= ae[d];
      sd[d] <= se[d] && !(d == 0 && int'(rc[d]) == drop_rc);
      rd[d] <= re[d];
      md[d] <= me[d];
    end
  end

  int checks = 0;
  int errors = 0;
  exp_t qa[$];
  exp_t qb[$];

  task automatic cmp(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  function automatic exp_t mk(input int lat, input int key, input int nr);
    exp_t e;
    e.lat = lat; e.key = key; e.ark = nr + 1; e.sub = nr; e.shf = nr;
    e.mix = nr - 1; e.fin = 2; e.ini = 2; e.dout = 1; e.maxrc = nr; e.bad = 0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int edge_n = 0;
  always @(posedge CLK) edge_n = edge_n + 1;

  int acc_e[2], c_key[2], c_ark[2], c_sub[2], c_shf[2], c_mix[2];
  int c_fin[2], c_ini[2], c_dout[2], c_max[2], c_bad[2];
  logic ovp[2];

  task automatic clr(input int d);
    c_key[d] = 0; c_ark[d] = 0; c_sub[d] = 0; c_shf[d] = 0; c_mix[d] = 0;
    c_fin[d] = 0; c_ini[d] = 0; c_dout[d] = 0; c_max[d] = 0; c_bad[d] = 0;
  endtask

  task automatic score(input int d);
    exp_t e;
    string p;
    p = (d == 0) ? "a_" : "b_";
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      cmp({p, "unexpected_out_valid"}, 1, 0);
      return;
    end
    e = (d == 0) ? qa.pop_front() : qb.pop_front();
    cmp({p, "latency"}, edge_n - acc_e[d], e.lat);
    cmp({p, "key_pulses"}, c_key[d], e.key);
    cmp({p, "ark_pulses"}, c_ark[d], e.ark);
    cmp({p, "sub_pulses"}, c_sub[d], e.sub);
    cmp({p, "shift_pulses"}, c_shf[d], e.shf);
    cmp({p, "mix_pulses"}, c_mix[d], e.mix);
    cmp({p, "final_sel_cycles"}, c_fin[d], e.fin);
    cmp({p, "init_sel_cycles"}, c_ini[d], e.ini);
    cmp({p, "data_out_pulses"}, c_dout[d], e.dout);
    cmp({p, "max_round"}, c_max[d], e.maxrc);
    cmp({p, "sel_mix_misplaced"}, c_bad[d], e.bad);
  endtask

  always @(negedge CLK) begin
    for (int d = 0; d < 2; d++) begin
      int nr;
      nr = (d == 0) ? 10 : 14;
      if (RST) begin
        clr(d);
        ovp[d] = 1'b0;
      end else begin
        c_key[d]  += int'(kx[d]);
        c_ark[d]  += int'(ae[d]);
        c_sub[d]  += int'(se[d]);
        c_shf[d]  += int'(re[d]);
        c_mix[d]  += int'(me[d]);
        c_fin[d]  += int'(dsf[d]);
        c_ini[d]  += int'(dsi[d]);
        c_dout[d] += int'(doe[d]);
        if (int'(rc[d]) > c_max[d]) c_max[d] = int'(rc[d]);
        if ((dsf[d] && int'(rc[d]) != nr) || (me[d] && int'(rc[d]) == nr) ||
            (dsi[d] && rc[d] != 4'd0))
          c_bad[d]++;
        if (ivl[d] && rdy[d] && !abt[d]) begin
          clr(d);
          acc_e[d] = edge_n + 1;
        end
        if (ov[d] && !ovp[d]) score(d);
        ovp[d] = ov[d];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int d, input logic kl);
    int n;
    n = 0;
    while (!rdy[d] && n < 50) begin tick(); n++; end
    if (!rdy[d]) cmp("send_wait_in_ready", 0, 1);
    if (d == 0) begin ia.in_valid = 1'b1; ia.key_load = kl; end
    else        begin ib.in_valid = 1'b1; ib.key_load = kl; end
    tick();
    if (d == 0) ia.in_valid = 1'b0; else ib.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (!(rdy[d] && !ov[d]) && n < 300) begin tick(); n++; end
    if (!(rdy[d] && !ov[d])) cmp("wait_idle_timeout", 0, 1);
  endtask

  function automatic int any_en(input int d);
    return int'(kx[d] | ae[d] | se[d] | re[d] | me[d] | doe[d]);
  endfunction

  initial begin
    int n;
    ia.in_valid = 0; ia.key_load = 0; ia.abort = 0; ia.out_ready = 1;
    ib.in_valid = 0; ib.key_load = 0; ib.abort = 0; ib.out_ready = 1;
    tick(); tick();
    RST = 1'b0;
    tick();

    // reset state
    cmp("rst_in_ready", int'(rdy[0]), 1);
    cmp("rst_busy", int'(bsy[0]), 0);
    cmp("rst_round", int'(rc[0]), 0);
    cmp("rst_out_valid", int'(ov[0]), 0);
    cmp("rst_timeout_err", int'(terr[0]), 0);
    cmp("rst_enables", any_en(0) + int'(dsi[0]) + int'(dsf[0]), 0);

    // AES-128, new key then reused key
    qa.push_back(mk(83, 1, 10)); send(0, 1'b1); wait_idle(0);
    qa.push_back(mk(81, 0, 10)); send(0, 1'b0); wait_idle(0);

    // output backpressure
    ia.out_ready = 1'b0;
    qa.push_back(mk(81, 0, 10)); send(0, 1'b0);
    n = 0;
    while (!ov[0] && n < 200) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      cmp("hold_out_valid", int'(ov[0]), 1);
      cmp("hold_in_ready", int'(rdy[0]), 0);
      tick();
    end
    ia.out_ready = 1'b1;
    wait_idle(0);

    // abort while idle is a no-op and blocks the accept
    ia.abort = 1'b1; ia.in_valid = 1'b1;
    tick();
    ia.abort = 1'b0; ia.in_valid = 1'b0;
    cmp("idle_abort_busy", int'(bsy[0]), 0);

    // watchdog: withhold sub_bytes_done in round 3
    drop_rc = 3;
    send(0, 1'b0);
    n = 0;
    while (!(se[0] && rc[0] == 4'd3) && n < 100) begin tick(); n++; end
    cmp("to_reached_round3_sub", int'(se[0] && rc[0] == 4'd3), 1);
    tick(); tick(); tick();
    cmp("to_not_yet", int'(terr[0]), 0);
    tick();
    cmp("to_err_set", int'(terr[0]), 1);
    cmp("to_idle", int'(rdy[0]), 1);
    cmp("to_round0", int'(rc[0]), 0);
    cmp("to_enables", any_en(0) + int'(ov[0]), 0);
    drop_rc = 99;
    qa.push_back(mk(83, 1, 10)); send(0, 1'b0);
    cmp("to_err_cleared_on_accept", int'(terr[0]), 0);
    wait_idle(0);

    // abort during round 5 MIX
    send(0, 1'b0);
    n = 0;
    while (!(me[0] && rc[0] == 4'd5) && n < 100) begin tick(); n++; end
    cmp("ab_reached_round5_mix", int'(me[0] && rc[0] == 4'd5), 1);
    ia.abort = 1'b1;
    tick();
    ia.abort = 1'b0;
    cmp("ab_busy", int'(bsy[0]), 0);
    cmp("ab_round0", int'(rc[0]), 0);
    cmp("ab_enables", any_en(0) + int'(ov[0]), 0);
    cmp("ab_timeout_err", int'(terr[0]), 0);
    tick();
    qa.push_back(mk(81, 0, 10)); send(0, 1'b0); wait_idle(0);

    // AES-256
    qb.push_back(mk(115, 1, 14)); send(1, 1'b1); wait_idle(1);
    qb.push_back(mk(113, 0, 14)); send(1, 1'b0); wait_idle(1);

    // asynchronous reset mid round 7
    send(0, 1'b0);
    n = 0;
    while (rc[0] != 4'd7 && n < 100) begin tick(); n++; end
    cmp("rst_reached_round7", int'(rc[0]), 7);
    RST = 1'b1;
    #1;
    cmp("arst_in_ready", int'(rdy[0]), 1);
    cmp("arst_busy", int'(bsy[0]), 0);
    cmp("arst_round", int'(rc[0]), 0);
    cmp("arst_outputs", any_en(0) + int'(ov[0]) + int'(dsi[0]) + int'(dsf[0]), 0);
    tick();
    RST = 1'b0;
    tick();
    qa.push_back(mk(83, 1, 10)); send(0, 1'b0); wait_idle(0);

    tick(); tick();
    cmp("scoreboard_a_drained", qa.size(), 0);
    cmp("scoreboard_b_drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1);
  end

endmodule
